rom_download_ctrl: RTL and testbench

// - Download sequencer between the HPS ioctl stream and the two ROM stores (DDR3 and SDRAM).
// - Takes 16-bit ioctl words and optionally bit-reverses each byte.
// - Issues one toggle write request per word, holds ioctl_wait until both stores acknowledge, then advances the address.
// - Also reports the console type (SGX), the Populous signature, the 512-byte copier header and the final ROM size to pce_top.

---
 rtl/rom_download_if.sv | 34 +++
 rtl/rom_download_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_rom_download_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_download_if.sv
// Signal bundle between the hps_io download stream, the two ROM stores and the download sequencer.
// The sequencer is the slave of the stream; master is the stream/store side.
interface rom_download_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   logic        swap;
   logic        rom_wr;
   logic        dd_wrack;
   logic        sd_wrack;
   logic [23:0] romwr_a;
   logic [15:0] romwr_d;
   logic        sgx;
   logic [1:0]  populous;
   logic        hdr;
   logic [23:0] rom_size;
   logic        dl_done;
   logic        err_timeout;
   logic        err_overrun;

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, swap, dd_wrack, sd_wrack,
      output ioctl_wait, rom_wr, romwr_a, romwr_d, sgx, populous, hdr, rom_size, dl_done,
             err_timeout, err_overrun
   );

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, swap, dd_wrack, sd_wrack,
      input  ioctl_wait, rom_wr, romwr_a, romwr_d, sgx, populous, hdr, rom_size, dl_done,
             err_timeout, err_overrun
   );
endinterface

// File: rtl/rom_download_ctrl.sv
// Download sequencer: ioctl words -> toggle write requests to DDR3/SDRAM ROM stores,
// plus console type, Populous signature, copier header and ROM size reporting.
//
// state | meaning
// IDLE  | waiting for a download window to open
// RECV  | ready for the next ioctl word
// PEND  | write issued, ioctl_wait held until both stores ack (or watchdog expires)
// DONE  | one-cycle wrap-up: latch size/header, pulse dl_done
module rom_download_ctrl #(
   parameter logic [4:0]  SGX_INDEX = 5'd2,
   parameter int unsigned TIMEOUT_W = 16
) (
   input logic            clk_sys,
   input logic            reset_n,
   rom_download_if.slave  bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_PEND, ST_DONE} state_t;

   // Down-counter loaded so that terminal count lands on the (2**W-1)th PEND cycle.
   localparam logic [TIMEOUT_W-1:0] WD_LOAD = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic                  dl_q, dl_d;
   logic                  fall_q, fall_d;
   logic                  wait_q, wait_d;
   logic                  rom_wr_q, rom_wr_d;
   logic [23:0]           addr_q, addr_d;
   logic [15:0]           data_q, data_d;
   logic                  sgx_q, sgx_d;
   logic [1:0]            pop_q, pop_d;
   logic                  hdr_q, hdr_d;
   logic [23:0]           size_q, size_d;
   logic                  done_q, done_d;
   logic                  err_to_q, err_to_d;
   logic                  err_ov_q, err_ov_d;
   logic [TIMEOUT_W-1:0]  wd_q, wd_d;

   logic        dl_rise, dl_fall, acked, sig_chk;
   logic [15:0] word_in, sig_exp;
   logic        unused_idx;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
   endfunction

   assign unused_idx = ^bus.ioctl_index[7:5];
   assign dl_rise    = bus.ioctl_download & ~dl_q;
   assign dl_fall    = ~bus.ioctl_download & dl_q;
   assign word_in    = bus.swap ? {rev8(bus.ioctl_dout[15:8]), rev8(bus.ioctl_dout[7:0])}
                                : bus.ioctl_dout;
   assign acked      = (rom_wr_q == bus.dd_wrack) && (rom_wr_q == bus.sd_wrack);

   always_comb begin
      sig_exp = 16'h0000;
      sig_chk = 1'b0;
      if (addr_q[23:4] == 20'h00212 || addr_q[23:4] == 20'h001F2) begin
         sig_chk = 1'b1;
         case (addr_q[3:0])
            4'h6:    sig_exp = 16'h4F50;
            4'h8:    sig_exp = 16'h5550;
            4'hA:    sig_exp = 16'h4F4C;
            4'hC:    sig_exp = 16'h5355;
            default: sig_chk = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      dl_d     = bus.ioctl_download;
      fall_d   = fall_q;
      wait_d   = wait_q;
      rom_wr_d = rom_wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      sgx_d    = sgx_q;
      pop_d    = pop_q;
      hdr_d    = hdr_q;
      size_d   = size_q;
      done_d   = 1'b0;
      err_to_d = err_to_q;
      err_ov_d = err_ov_q;
      wd_d     = wd_q;

      // A new window restarts from any state; an in-flight toggle is simply abandoned.
      if (dl_rise) begin
         state_d  = ST_RECV;
         addr_d   = 24'h000000;
         pop_d    = 2'b11;
         sgx_d    = (bus.ioctl_index[4:0] == SGX_INDEX);
         err_to_d = 1'b0;
         err_ov_d = 1'b0;
         wait_d   = 1'b0;
         fall_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_RECV: begin
               if (bus.ioctl_wr) begin
                  data_d   = word_in;
                  rom_wr_d = ~rom_wr_q;
                  wait_d   = 1'b1;
                  wd_d     = WD_LOAD;
                  fall_d   = dl_fall;
                  state_d  = ST_PEND;
                  if (sig_chk && word_in != sig_exp) pop_d[addr_q[13]] = 1'b0;
               end else if (dl_fall) begin
                  state_d = ST_DONE;
               end
            end
            ST_PEND: begin
               if (bus.ioctl_wr) err_ov_d = 1'b1;
               if (dl_fall)      fall_d   = 1'b1;
               if (acked || wd_q == '0) begin
                  if (!acked) err_to_d = 1'b1;
                  wait_d  = 1'b0;
                  addr_d  = addr_q + 24'd2;
                  state_d = (fall_q || dl_fall) ? ST_DONE : ST_RECV;
               end else begin
                  wd_d = wd_q - WD_ONE;
               end
            end
            ST_DONE: begin
               size_d  = addr_q;
               hdr_d   = addr_q[9];
               done_d  = 1'b1;
               wait_d  = 1'b0;
               fall_d  = 1'b0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         dl_q     <= 1'b0;
         fall_q   <= 1'b0;
         wait_q   <= 1'b0;
         rom_wr_q <= 1'b0;
         addr_q   <= 24'h000000;
         data_q   <= 16'h0000;
         sgx_q    <= 1'b0;
         pop_q    <= 2'b11;
         hdr_q    <= 1'b0;
         size_q   <= 24'h000000;
         done_q   <= 1'b0;
         err_to_q <= 1'b0;
         err_ov_q <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         dl_q     <= dl_d;
         fall_q   <= fall_d;
         wait_q   <= wait_d;
         rom_wr_q <= rom_wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         sgx_q    <= sgx_d;
         pop_q    <= pop_d;
         hdr_q    <= hdr_d;
         size_q   <= size_d;
         done_q   <= done_d;
         err_to_q <= err_to_d;
         err_ov_q <= err_ov_d;
         wd_q     <= wd_d;
      end
   end

   assign bus.ioctl_wait  = wait_q;
   assign bus.rom_wr      = rom_wr_q;
   assign bus.romwr_a     = addr_q;
   assign bus.romwr_d     = data_q;
   assign bus.sgx         = sgx_q;
   assign bus.populous    = pop_q;
   assign bus.hdr         = hdr_q;
   assign bus.rom_size    = size_q;
   assign bus.dl_done     = done_q;
   assign bus.err_timeout = err_to_q;
   assign bus.err_overrun = err_ov_q;
endmodule

// File: tb/tb_rom_download_ctrl.sv
// Bench for rom_download_ctrl: table of whole downloads checked through a write scoreboard,
// then hand-written watchdog, overrun, late-drop and reset sequences.
module tb_rom_download_ctrl;
   localparam int TW = 6;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   rom_download_if bus();

   rom_download_ctrl #(.SGX_INDEX(5'd2), .TIMEOUT_W(TW)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [23:0] a;
      logic [15:0] d;
   } sb_t;

   typedef struct {
      logic [7:0]       idx;
      logic             swp;
      int               nwords;
      int               ack_dly;
      logic             lit;
      logic             sig;
      logic [3:0][15:0] w;
      logic [3:0][15:0] ed;
      logic             exp_sgx;
      logic [23:0]      exp_size;
      logic             exp_hdr;
      logic [1:0]       exp_pop;
   } dl_vec_t;

   sb_t     sb_q[$];
   dl_vec_t vecs[5];
   int      n_chk = 0;
   int      n_fail = 0;
   logic    ack_hold = 1'b0;
   int      ack_dly = 0;
   int      ack_cnt = 0;
   int      wait_win = 0;
   int      done_cnt = 0;
   logic    rom_wr_prev = 1'b0;
   logic    wait_prev = 1'b0;
   logic    exp_rom_wr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Store model: both acks follow rom_wr after ack_dly cycles unless held.
   initial begin
      bus.dd_wrack = 1'b0;
      bus.sd_wrack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!ack_hold && reset_n && bus.rom_wr !== bus.dd_wrack) begin
            if (ack_cnt >= ack_dly) begin
               bus.dd_wrack = bus.rom_wr;
               bus.sd_wrack = bus.rom_wr;
               ack_cnt = 0;
            end else begin
               ack_cnt++;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   // Scoreboard: every rom_wr toggle must match the oldest queued word.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if (bus.rom_wr !== rom_wr_prev) begin
               n_chk++;
               if (sb_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_underflow: rom_wr toggled at romwr_a=%0h with no write queued", bus.romwr_a);
               end else begin
                  e = sb_q.pop_front();
                  check("sb_addr", 32'(bus.romwr_a), 32'(e.a));
                  check("sb_data", 32'(bus.romwr_d), 32'(e.d));
               end
            end
            if (bus.ioctl_wait && !wait_prev) wait_win++;
            if (bus.dl_done) done_cnt++;
         end
         rom_wr_prev = bus.rom_wr;
         wait_prev   = bus.ioctl_wait;
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "time limit");
   end

   function automatic logic [15:0] word_of(input dl_vec_t v, input int i);
      logic [15:0] a;
      a = 16'(2 * i);
      if (v.lit && i < 4) return v.w[i];
      if (v.sig && (a[15:4] == 12'h1F2 || a[15:4] == 12'h212)) begin
         case (a[3:0])
            4'h6: return 16'h4F50;
            4'h8: return 16'h5550;
            4'hA: return (a[15:4] == 12'h212) ? 16'h4F4D : 16'h4F4C;
            4'hC: return 16'h5355;
            default: ;
         endcase
      end
      return 16'(i) ^ 16'h5A5A;
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.ioctl_wait === 1'b1 && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check({tag, "_wait_release"}, 32'(n >= 200), 32'd0);
   endtask

   task automatic send_word(input logic [15:0] w, input logic [23:0] a, input logic [15:0] ed);
      wait_ready("send");
      bus.ioctl_dout = w;
      bus.ioctl_wr   = 1'b1;
      sb_q.push_back('{a: a, d: ed});
      exp_rom_wr = ~exp_rom_wr;
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
   endtask

   task automatic start_dl(input logic [7:0] idx, input logic swp);
      bus.ioctl_index    = idx;
      bus.swap           = swp;
      bus.ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_wait"},     32'(bus.ioctl_wait),  32'd0);
      check({tag, "_rom_wr"},   32'(bus.rom_wr),      32'd0);
      check({tag, "_romwr_a"},  32'(bus.romwr_a),     32'd0);
      check({tag, "_romwr_d"},  32'(bus.romwr_d),     32'd0);
      check({tag, "_sgx"},      32'(bus.sgx),         32'd0);
      check({tag, "_populous"}, 32'(bus.populous),    32'd3);
      check({tag, "_hdr"},      32'(bus.hdr),         32'd0);
      check({tag, "_rom_size"}, 32'(bus.rom_size),    32'd0);
      check({tag, "_dl_done"},  32'(bus.dl_done),     32'd0);
      check({tag, "_err_to"},   32'(bus.err_timeout), 32'd0);
      check({tag, "_err_ov"},   32'(bus.err_overrun), 32'd0);
   endtask

   task automatic run_vec(input int k, input dl_vec_t v);
      string t;
      logic [15:0] w, ed;
      t = $sformatf("vec%0d", k);
      wait_win = 0;
      done_cnt = 0;
      ack_dly  = v.ack_dly;
      start_dl(v.idx, v.swp);
      for (int i = 0; i < v.nwords; i++) begin
         w  = word_of(v, i);
         ed = (v.lit && i < 4) ? v.ed[i] : w;
         send_word(w, 24'(2 * i), ed);
      end
      wait_ready(t);
      bus.ioctl_download = 1'b0;
      wait_done(t);
      repeat (3) @(negedge clk_sys);
      check({t, "_sgx"},      32'(bus.sgx),         32'(v.exp_sgx));
      check({t, "_rom_size"}, 32'(bus.rom_size),    32'(v.exp_size));
      check({t, "_hdr"},      32'(bus.hdr),         32'(v.exp_hdr));
      check({t, "_populous"}, 32'(bus.populous),    32'(v.exp_pop));
      check({t, "_done_cnt"}, 32'(done_cnt),        32'd1);
      check({t, "_wait_win"}, 32'(wait_win),        32'(v.nwords));
      check({t, "_err_to"},   32'(bus.err_timeout), 32'd0);
      check({t, "_err_ov"},   32'(bus.err_overrun), 32'd0);
   endtask

   initial begin
      int n;
      vecs[0] = '{idx: 8'h00, swp: 1'b0, nwords: 4, ack_dly: 3, lit: 1'b1, sig: 1'b0,
                  w:  {16'h8000, 16'h0001, 16'hABCD, 16'h1234},
                  ed: {16'h8000, 16'h0001, 16'hABCD, 16'h1234},
                  exp_sgx: 1'b0, exp_size: 24'h000008, exp_hdr: 1'b0, exp_pop: 2'b11};
      vecs[1] = '{idx: 8'h02, swp: 1'b1, nwords: 2, ack_dly: 1, lit: 1'b1, sig: 1'b0,
                  w:  {16'h0000, 16'h0000, 16'hF00F, 16'h0180},
                  ed: {16'h0000, 16'h0000, 16'h0FF0, 16'h8001},
                  exp_sgx: 1'b1, exp_size: 24'h000004, exp_hdr: 1'b0, exp_pop: 2'b11};
      vecs[2] = '{idx: 8'h01, swp: 1'b0, nwords: 'h101, ack_dly: 0, lit: 1'b0, sig: 1'b0,
                  w: '0, ed: '0,
                  exp_sgx: 1'b0, exp_size: 24'h000202, exp_hdr: 1'b1, exp_pop: 2'b11};
      vecs[3] = '{idx: 8'h22, swp: 1'b0, nwords: 'h201, ack_dly: 2, lit: 1'b0, sig: 1'b0,
                  w: '0, ed: '0,
                  exp_sgx: 1'b1, exp_size: 24'h000402, exp_hdr: 1'b0, exp_pop: 2'b11};
      // Good signature in the 0x1F2x block (index 0), one bad byte at 0x212A (index 1).
      vecs[4] = '{idx: 8'h03, swp: 1'b0, nwords: 'h1098, ack_dly: 0, lit: 1'b0, sig: 1'b1,
                  w: '0, ed: '0,
                  exp_sgx: 1'b0, exp_size: 24'h002130, exp_hdr: 1'b0, exp_pop: 2'b01};

      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'h00;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_dout     = 16'h0000;
      bus.swap           = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_reset_vals("por");
      reset_n = 1'b1;
      @(negedge clk_sys);

      for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

      // Watchdog expiry with an overrun word thrown in while pending.
      ack_dly  = 0;
      ack_hold = 1'b1;
      done_cnt = 0;
      start_dl(8'h00, 1'b0);
      check("restart_populous", 32'(bus.populous), 32'd3);
      send_word(16'h1111, 24'h000000, 16'h1111);
      n = 1;
      bus.ioctl_dout = 16'h2222;
      bus.ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      n++;
      check("ovr_flag",    32'(bus.err_overrun), 32'd1);
      check("ovr_romwr_d", 32'(bus.romwr_d),     32'h1111);
      check("to_early",    32'(bus.err_timeout), 32'd0);
      while (bus.ioctl_wait === 1'b1 && n < 200) begin
         @(negedge clk_sys);
         if (bus.ioctl_wait) n++;
      end
      check("to_cycles",  32'(n),               32'((1 << TW) - 1));
      check("to_flag",    32'(bus.err_timeout), 32'd1);
      check("to_addr",    32'(bus.romwr_a),     32'h000002);
      check("to_rom_wr",  32'(bus.rom_wr),      32'(exp_rom_wr));
      ack_hold = 1'b0;
      send_word(16'h3333, 24'h000002, 16'h3333);
      wait_ready("to");
      bus.ioctl_download = 1'b0;
      wait_done("to");
      repeat (2) @(negedge clk_sys);
      check("to_rom_size", 32'(bus.rom_size),    32'h000004);
      check("to_sticky",   32'(bus.err_timeout), 32'd1);

      // Window closes while a write is pending: DONE only once acks arrive.
      done_cnt = 0;
      start_dl(8'h00, 1'b0);
      check("clr_err_to", 32'(bus.err_timeout), 32'd0);
      check("clr_err_ov", 32'(bus.err_overrun), 32'd0);
      ack_hold = 1'b1;
      send_word(16'h5555, 24'h000000, 16'h5555);
      bus.ioctl_download = 1'b0;
      repeat (5) @(negedge clk_sys);
      check("drop_no_done", 32'(done_cnt),       32'd0);
      check("drop_waiting", 32'(bus.ioctl_wait), 32'd1);
      ack_hold = 1'b0;
      wait_done("drop");
      repeat (2) @(negedge clk_sys);
      check("drop_rom_size", 32'(bus.rom_size), 32'h000002);
      check("drop_done_cnt", 32'(done_cnt),     32'd1);
      bus.ioctl_dout = 16'h9999;
      bus.ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("idle_wr_rom_wr", 32'(bus.rom_wr),      32'(exp_rom_wr));
      check("idle_wr_err_ov", 32'(bus.err_overrun), 32'd0);
      check("idle_wr_wait",   32'(bus.ioctl_wait),  32'd0);

      // Asynchronous reset in the middle of a pending write.
      start_dl(8'h02, 1'b0);
      ack_hold = 1'b1;
      send_word(16'h7777, 24'h000000, 16'h7777);
      check("pre_rst_sgx", 32'(bus.sgx), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals("rst_async");
      @(negedge clk_sys);
      check_reset_vals("rst_edge");
      bus.ioctl_download = 1'b0;
      bus.dd_wrack = 1'b0;
      bus.sd_wrack = 1'b0;
      exp_rom_wr = 1'b0;
      ack_hold   = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      check("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
